// File: rtl/ecc_sec32_pkg.sv
// Shared constants and codeword type for the 32-bit SEC encoder/decoder family.
package ecc_sec32_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned CW_W   = DATA_W + CHK_W;

  // Duals of the corrector's syndrome equations; c[k] = ^(data & CHK_MASK[k])
  localparam logic [DATA_W-1:0] CHK_MASK [0:CHK_W-1] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  typedef struct packed {
    logic [CHK_W-1:0]  check;
    logic [DATA_W-1:0] data;
  } codeword_t;

endpackage

// File: rtl/ecc_sec32_parity.sv
// Combinational check-bit generator shared by the SEC32 encoder and decoder variants.
module ecc_sec32_parity
  import ecc_sec32_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CHK_W-1:0]  check_c
);

  always_comb begin
    check_c = '0;
    for (int k = 0; k < int'(CHK_W); k++) begin
      check_c[k] = ^(data_i & CHK_MASK[k]);
    end
  end

endmodule

// File: rtl/ecc_sec32_encoder.sv
// Streaming SEC32 check-bit encoder: output register plus one skid entry, FIFO order.
// Optional one-shot fault injection is enabled by defining ECC_ERR_INJECT_EN.
module ecc_sec32_encoder
  import ecc_sec32_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef ECC_ERR_INJECT_EN
  input  logic              inj_arm,
  input  logic [5:0]        inj_pos,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  codeword_t        out_word_q, out_word_d;
  codeword_t        skid_word_q, skid_word_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inj_armed_q, inj_armed_d;

  logic [CHK_W-1:0] in_check_c;
  logic [CW_W-1:0]  flip_c;
  codeword_t        in_word_c;
  logic             accept_c;
  logic             drain_c;

  ecc_sec32_parity u_parity (
    .data_i  (in_data),
    .check_c (in_check_c)
  );

  assign accept_c = in_valid && in_ready_q;
  assign drain_c  = out_valid_q && out_ready;

`ifdef ECC_ERR_INJECT_EN
  // Armed fault applies to the next accepted word, including one accepted in the arming cycle
  always_comb begin
    flip_c      = '0;
    inj_armed_d = inj_armed_q;
    if ((inj_armed_q || inj_arm) && (inj_pos < 6'd40)) begin
      flip_c = CW_W'(1) << inj_pos;
    end
    if (accept_c) begin
      inj_armed_d = 1'b0;
    end else if (inj_arm) begin
      inj_armed_d = 1'b1;
    end
  end
`else
  always_comb begin
    flip_c      = '0;
    inj_armed_d = 1'b0;
  end
`endif

  assign in_word_c = codeword_t'({in_check_c, in_data} ^ flip_c);

  // Occupancy FSM: EMPTY/ONE/TWO over the output register and skid entry
  always_comb begin
    state_d     = state_q;
    out_word_d  = out_word_q;
    skid_word_d = skid_word_q;
    count_d     = count_q;
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          out_word_d = in_word_c;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept_c && drain_c) begin
          out_word_d = in_word_c;
        end else if (accept_c) begin
          skid_word_d = in_word_c;
          state_d     = TWO;
        end else if (drain_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain_c) begin
          out_word_d = skid_word_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (drain_c) begin
      count_d = count_q + CNT_W'(1);
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_word_q  <= '0;
      skid_word_q <= '0;
      count_q     <= '0;
      inj_armed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_word_q  <= out_word_d;
      skid_word_q <= skid_word_d;
      count_q     <= count_d;
      inj_armed_q <= inj_armed_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_word_q.data;
  assign out_check = out_word_q.check;
  assign out_count = count_q;

endmodule
